truth_table_sweep: RTL
======================

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter N_IN, default 2: gate input count, legal range 2..8.
REQ-002 Parameter HOLD, default 1: cycles each input vector is held, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin sweep; sampled only in IDLE.
REQ-006 op  input  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 decode as AND.
REQ-007 vec  output  N_IN  input vector currently applied, bit 0 = first input.
REQ-008 y  output  1  op reduced over all bits of vec, registered together with vec.
REQ-009 valid  output  1  high on the first cycle of each new vector only.
REQ-010 busy  output  1  high while sweep is running.
REQ-011 done  output  1  one-cycle pulse at sweep end.
REQ-012 ones_cnt  output  N_IN+1  number of presented vectors with y=1.

Function
REQ-013 FSM states IDLE, RUN, DONE; transitions IDLE->RUN on start=1; RUN->DONE after the last vector's HOLD cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-014 op shall be latched when start is accepted; op changes during RUN shall have no effect.
REQ-015 Start accepted at cycle t: cycle t+1 gives vec=0, y=f(0), valid=1, busy=1, ones_cnt=y.
REQ-016 Vector k (0..2**N_IN-1) shall be presented at cycle t+1+k*HOLD, ascending binary, no skips.
REQ-017 ones_cnt shall update in the same cycle a vector is presented, including that vector's y.
REQ-018 ones_cnt shall clear to 0 when start is accepted, before counting vector 0.
REQ-019 At cycle t+1+2**N_IN*HOLD: state DONE, done=1, busy=0, valid=0.
REQ-020 After DONE, vec, y and ones_cnt shall hold their final values until next accepted start or reset.
REQ-021 start in RUN or DONE shall be ignored; it shall not restart or extend the sweep.
REQ-022 start held high continuously shall launch a new sweep on the first IDLE cycle after DONE.
REQ-023 Vector counter shall not wrap: the sweep shall end after vector all-ones, never return to 0 within a run.
REQ-024 ones_cnt range 0..2**N_IN shall fit N_IN+1 bits without overflow.

Reset
REQ-025 rst=1 at any edge shall force IDLE with vec=0, y=0, valid=0, busy=0, done=0, ones_cnt=0, HOLD counter=0.
REQ-026 rst asserted mid-RUN shall abort the sweep with no done pulse; start is ignored while rst=1.

Configuration
REQ-027 With TRUTH_TABLE_SIGNATURE_EN defined: extra output signature, width 2**N_IN, bit k = y of vector k, written when vector k is presented, cleared on reset and on accepted start.
REQ-028 Without TRUTH_TABLE_SIGNATURE_EN: signature port and its storage absent; all other behaviour identical.

Verification
REQ-029 N_IN=2, HOLD=1, op=AND, start at cycle 0 -> vec 00,01,10,11 at cycles 1-4, y 0,0,0,1, valid every cycle 1-4, done at cycle 5, ones_cnt=1.
REQ-030 N_IN=3, HOLD=2, op=XOR -> each vec held 2 cycles, valid on alternate cycles, done at cycle 17, ones_cnt=4, signature=8'b10010110.
REQ-031 N_IN=2, op=NOR then op=NAND runs -> ones_cnt=1 then 3; signature 4'b0001 then 4'b0111; ones_cnt cleared between runs.
REQ-032 start pulsed again at cycle 3 and op changed to OR at cycle 2 of AND run -> no restart, done still at cycle 5, ones_cnt=1.
REQ-033 rst at cycle 3 of N_IN=2 HOLD=1 run -> next cycle all outputs 0, no done pulse; new start then runs full sweep correctly.
REQ-034 op=7, N_IN=2 -> results identical to AND (ones_cnt=1); start held high -> back-to-back sweeps with one IDLE cycle between done and next vec=0.

Source files
------------

// File: rtl/truth_table_sweep.sv
// Sweeps an N_IN-input gate through every input vector in ascending order, HOLD cycles per vector.
// Optional TRUTH_TABLE_SIGNATURE_EN adds a 2**N_IN-bit signature output (bit k = y of vector k).
module truth_table_sweep #(
    parameter int N_IN = 2,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    output logic [N_IN-1:0] vec,
    output logic            y,
    output logic            valid,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_cnt
`ifdef TRUTH_TABLE_SIGNATURE_EN
    ,
    output logic [(1<<N_IN)-1:0] signature
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [7:0]      hold_q, hold_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            y_q, y_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N_IN:0]   ones_q, ones_d;
`ifdef TRUTH_TABLE_SIGNATURE_EN
    logic [(1<<N_IN)-1:0] sig_q, sig_d;
`endif

    // Unused op codes 6 and 7 fall through to AND.
    function automatic logic gate(input logic [2:0] sel, input logic [N_IN-1:0] v);
        case (sel)
            3'd1:    gate = |v;
            3'd2:    gate = ^v;
            3'd3:    gate = ~&v;
            3'd4:    gate = ~|v;
            3'd5:    gate = ~^v;
            default: gate = &v;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        y_d     = y_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ones_d  = ones_q;
`ifdef TRUTH_TABLE_SIGNATURE_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    hold_d  = '0;
                    vec_d   = '0;
                    y_d     = gate(op, {N_IN{1'b0}});
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    ones_d  = (N_IN+1)'(y_d);
`ifdef TRUTH_TABLE_SIGNATURE_EN
                    sig_d    = '0;
                    sig_d[0] = y_d;
`endif
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    // Stop after all-ones rather than letting the vector wrap to 0.
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        y_d     = gate(op_q, vec_d);
                        valid_d = 1'b1;
                        ones_d  = ones_q + (N_IN+1)'(y_d);
`ifdef TRUTH_TABLE_SIGNATURE_EN
                        sig_d[vec_d] = y_d;
`endif
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            hold_q  <= '0;
            vec_q   <= '0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= '0;
`ifdef TRUTH_TABLE_SIGNATURE_EN
            sig_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
`ifdef TRUTH_TABLE_SIGNATURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign vec      = vec_q;
    assign y        = y_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;
`ifdef TRUTH_TABLE_SIGNATURE_EN
    assign signature = sig_q;
`endif

endmodule
